piece_bag_queue: RTL and testbench

//  Parametrised next-piece source for the tetris core: keeps a circular queue of QSIZE

---
 rtl/piece_bag_queue.sv | 140 ++++++++++++++
 tb/tb_piece_bag_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_bag_queue.sv
// rtl/piece_bag_queue.sv - circular next-piece queue refilled each cycle from an LFSR-driven piece generator
// Define BAG7_EN to draw pieces as 7-bag permutations; otherwise independent LFSR draws are used.
module piece_bag_queue #(
  parameter int                QSIZE   = 16,
  parameter int                PREVIEW = 3,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic                         seed_load,
  input  logic [LFSR_W-1:0]            seed,
  input  logic                         pop,
  output logic [2:0]                   head_kind,
  output logic                         head_vld,
  output logic [3*PREVIEW-1:0]         preview,
  output logic [$clog2(QSIZE+1)-1:0]   count,
  output logic                         full
);

  localparam int                PW   = (QSIZE > 1) ? $clog2(QSIZE) : 1;
  localparam int                CW   = $clog2(QSIZE+1);
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400);
  localparam logic [PW-1:0]     LAST = PW'(QSIZE-1);

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [2:0]        mem_q [QSIZE];
  logic [2:0]        kind;
  logic              empty_w, full_w, pop_eff, push, wr_en;
  int                pv_idx;

  // Pointers wrap modulo QSIZE so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? PW'(0) : p + 1'b1;
  endfunction

`ifdef BAG7_EN
  logic [6:0] mask_q, mask_d, mask_set;
  logic [2:0] start;

  function automatic logic [2:0] kind_add(input logic [2:0] s, input int j);
    int v;
    v = int'(s) + j;
    if (v > 7) v = v - 7;
    return 3'(v);
  endfunction

  // Scan downward so the lowest offset from the start kind wins.
  always_comb begin
    start = (lfsr_q[2:0] == 3'd0) ? 3'd1 : lfsr_q[2:0];
    kind  = start;
    for (int j = 6; j >= 0; j--) begin
      if (!mask_q[kind_add(start, j) - 3'd1]) kind = kind_add(start, j);
    end
  end

  always_comb begin
    mask_set = mask_q | (7'd1 << (kind - 3'd1));
    mask_d   = mask_q;
    if (clr)       mask_d = '0;
    else if (push) mask_d = (mask_set == 7'h7F) ? 7'h00 : mask_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mask_q <= '0;
    else          mask_q <= mask_d;
  end
`else
  always_comb begin
    kind = (lfsr_q[2:0] != 3'd0) ? lfsr_q[2:0] : (lfsr_q[5:3] | 3'd1);
  end
`endif

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(QSIZE));
  assign pop_eff = pop && !empty_w;
  assign push    = !full_w || pop_eff;
  assign wr_en   = push && !clr;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_eff) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push)    wr_ptr_d = ptr_inc(wr_ptr_q);
      if (push && !pop_eff) count_d = count_q + 1'b1;
    end
  end

  // The LFSR keeps stepping through clr and full; only seed_load overrides it.
  always_comb begin
    if (seed_load)      lfsr_d = (seed == '0) ? SEED : seed;
    else if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ TAPS;
    else                lfsr_d = lfsr_q >> 1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      lfsr_q   <= SEED;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // Storage needs no reset: every read is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= kind;
  end

  assign head_kind = empty_w ? 3'd0 : mem_q[rd_ptr_q];
  assign head_vld  = !empty_w;
  assign count     = count_q;
  assign full      = full_w;

  always_comb begin
    preview = '0;
    pv_idx  = 0;
    for (int i = 0; i < PREVIEW; i++) begin
      pv_idx = int'(rd_ptr_q) + 1 + i;
      if (pv_idx >= QSIZE) pv_idx = pv_idx - QSIZE;
      if (int'(count_q) > i + 1) preview[3*i +: 3] = mem_q[PW'(pv_idx)];
    end
  end

endmodule

// File: tb/tb_piece_bag_queue.sv
// tb/tb_piece_bag_queue.sv - randomized self-checking bench for piece_bag_queue against a queue-level model
module tb_piece_bag_queue;

  localparam int          QS     = 16;
  localparam int          QS5    = 5;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0, seed_load = 1'b0, pop = 1'b0;
  logic [15:0] seed = '0;
  logic [2:0]  head_kind;
  logic        head_vld, full;
  logic [8:0]  preview;
  logic [4:0]  count;

  logic        clr5 = 1'b0, seed_load5 = 1'b0, pop5 = 1'b0;
  logic [15:0] seed5 = '0;
  logic [2:0]  head_kind5;
  logic        head_vld5, full5;
  logic [8:0]  preview5;
  logic [2:0]  count5;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_lfsr [2];
  logic [6:0]  m_used [2];
  int          mq [2][$];
  logic [2:0]  ref_seq [20];

  piece_bag_queue #(.QSIZE(QS), .PREVIEW(3), .LFSR_W(16), .SEED(SEED_V)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .seed_load(seed_load), .seed(seed), .pop(pop),
    .head_kind(head_kind), .head_vld(head_vld), .preview(preview), .count(count), .full(full)
  );

  piece_bag_queue #(.QSIZE(QS5), .PREVIEW(3), .LFSR_W(16), .SEED(SEED_V)) dut5 (
    .clk(clk), .reset_n(reset_n), .clr(clr5), .seed_load(seed_load5), .seed(seed5), .pop(pop5),
    .head_kind(head_kind5), .head_vld(head_vld5), .preview(preview5), .count(count5), .full(full5)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic int draw(input logic [15:0] x, input logic [6:0] used);
`ifdef BAG7_EN
    int c;
    c = int'(x[2:0]);
    if (c == 0) c = 1;
    for (int j = 0; j < 7; j++) begin
      int kk;
      kk = ((c - 1 + j) % 7) + 1;
      if (!used[kk-1]) return kk;
    end
    return 0;
`else
    if (used == 7'h7F) return 0;
    if (x[2:0] != 3'd0) return int'(x[2:0]);
    return int'(x[5:3]) | 1;
`endif
  endfunction

  function automatic int cap(input int id);
    return (id == 0) ? QS : QS5;
  endfunction

  function automatic void model_reset();
    for (int id = 0; id < 2; id++) begin
      m_lfsr[id] = SEED_V;
      m_used[id] = '0;
      mq[id].delete();
    end
  endfunction

  function automatic void model_edge(input int id, input logic c, input logic sl,
                                     input logic [15:0] sd, input logic p);
    int k, n;
    bit pe, ps;
    k  = draw(m_lfsr[id], m_used[id]);
    n  = mq[id].size();
    pe = p && (n != 0);
    ps = (n != cap(id)) || pe;
    if (c) begin
      mq[id].delete();
      m_used[id] = '0;
    end else begin
      if (pe) void'(mq[id].pop_front());
      if (ps) begin
        mq[id].push_back(k);
        m_used[id][k-1] = 1'b1;
        if (m_used[id] == 7'h7F) m_used[id] = '0;
      end
    end
    m_lfsr[id] = sl ? ((sd == 16'h0) ? SEED_V : sd) : lfsr_next(m_lfsr[id]);
  endfunction

  function automatic logic [2:0] m_head(input int id);
    return (mq[id].size() != 0) ? 3'(mq[id][0]) : 3'd0;
  endfunction

  function automatic logic [8:0] m_prev(input int id);
    logic [8:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      if (mq[id].size() > i + 1) v[3*i +: 3] = 3'(mq[id][i+1]);
    return v;
  endfunction

  task automatic step(input logic c, input logic sl, input logic [15:0] sd, input logic p);
    clr = c; seed_load = sl; seed = sd; pop = p;
    @(posedge clk);
    model_edge(0, c, sl, sd, p);
    model_edge(1, clr5, seed_load5, seed5, pop5);
    @(negedge clk);
    clr = 1'b0; seed_load = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (head_vld !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got vld=%0b full=%0b want 0 0", head_vld, full); end
    n_cmp++; if (head_kind !== 3'd0 || preview !== 9'd0) begin n_bad++; $display("FAIL reset_data: got head=%0d prev=%h want 0 0", head_kind, preview); end
    n_cmp++; if (count5 !== 3'd0) begin n_bad++; $display("FAIL reset_count5: got %0d want 0", count5); end
    reset_n = 1'b1;
    n_cmp++; if (head_vld !== 1'b0) begin n_bad++; $display("FAIL release_vld: got %0b want 0", head_vld); end
  endtask

  task automatic test_fill();
    for (int cyc = 1; cyc <= QS; cyc++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      n_cmp++; if (head_vld !== 1'b1) begin n_bad++; $display("FAIL fill_vld c%0d: got %0b want 1", cyc, head_vld); end
      n_cmp++; if (count !== 5'(cyc)) begin n_bad++; $display("FAIL fill_count c%0d: got %0d want %0d", cyc, count, cyc); end
      n_cmp++; if (full !== (cyc == QS)) begin n_bad++; $display("FAIL fill_full c%0d: got %0b want %0b", cyc, full, cyc == QS); end
      n_cmp++; if (head_kind !== m_head(0) || preview !== m_prev(0)) begin
        n_bad++; $display("FAIL fill_data c%0d: got %0d/%h want %0d/%h", cyc, head_kind, preview, m_head(0), m_prev(0));
      end
    end
  endtask

  task automatic test_pop_stream();
    logic [2:0] got [70];
    for (int n = 0; n < 70; n++) begin
      got[n] = head_kind;
      n_cmp++; if (head_kind !== m_head(0) || preview !== m_prev(0)) begin
        n_bad++; $display("FAIL pop_data n%0d: got %0d/%h want %0d/%h", n, head_kind, preview, m_head(0), m_prev(0));
      end
      n_cmp++; if (head_kind === 3'd0) begin n_bad++; $display("FAIL pop_nonzero n%0d: got 0 want 1..7", n); end
      if (n < 20) ref_seq[n] = head_kind;
      step(1'b0, 1'b0, 16'h0, 1'b1);
      n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL pop_count n%0d: got %0d want 16", n, count); end
    end
`ifdef BAG7_EN
    for (int b = 0; b < 10; b++) begin
      logic [6:0] seen;
      seen = '0;
      for (int j = 0; j < 7; j++) if (got[7*b+j] != 3'd0) seen[got[7*b+j]-1] = 1'b1;
      n_cmp++; if (seen !== 7'h7F) begin n_bad++; $display("FAIL bag_perm b%0d: got mask %h want 7f", b, seen); end
    end
`endif
  endtask

  task automatic test_clr_pop();
    step(1'b1, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (count !== 5'd0 || head_vld !== 1'b0) begin n_bad++; $display("FAIL clr_count: got %0d/%0b want 0/0", count, head_vld); end
    n_cmp++; if (head_kind !== 3'd0 || preview !== 9'd0 || full !== 1'b0) begin
      n_bad++; $display("FAIL clr_data: got %0d/%h/%0b want 0/0/0", head_kind, preview, full);
    end
    step(1'b0, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL empty_pop_count: got %0d want 1", count); end
    n_cmp++; if (head_kind !== m_head(0)) begin n_bad++; $display("FAIL empty_pop_head: got %0d want %0d", head_kind, m_head(0)); end
  endtask

  task automatic test_seed_load();
    logic [2:0]  runs [3][20];
    logic [15:0] sv [3];
    int          nrec;
    sv[0] = 16'h0001; sv[1] = 16'h0001; sv[2] = 16'h0000;
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 1'b1, sv[r], 1'b1);
      nrec = 0;
      for (int c = 0; c < 21; c++) begin
        if (head_vld && nrec < 20) begin
          runs[r][nrec] = head_kind;
          nrec++;
        end
        n_cmp++; if (head_kind !== m_head(0) || count !== 5'(mq[0].size())) begin
          n_bad++; $display("FAIL seed_data r%0d c%0d: got %0d/%0d want %0d/%0d", r, c, head_kind, count, m_head(0), mq[0].size());
        end
        step(1'b0, 1'b0, 16'h0, 1'b1);
      end
      n_cmp++; if (nrec != 20) begin n_bad++; $display("FAIL seed_pops r%0d: got %0d want 20", r, nrec); end
    end
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (runs[1][i] !== runs[0][i]) begin n_bad++; $display("FAIL seed_repeat i%0d: got %0d want %0d", i, runs[1][i], runs[0][i]); end
      n_cmp++; if (runs[2][i] !== ref_seq[i]) begin n_bad++; $display("FAIL seed_zero i%0d: got %0d want %0d", i, runs[2][i], ref_seq[i]); end
    end
  endtask

  task automatic test_wrap5();
    n_cmp++; if (count5 !== 3'd5 || full5 !== 1'b1) begin n_bad++; $display("FAIL q5_full: got %0d/%0b want 5/1", count5, full5); end
    pop5 = 1'b1;
    for (int n = 0; n < 7; n++) begin
      n_cmp++; if (head_kind5 !== m_head(1) || preview5 !== m_prev(1)) begin
        n_bad++; $display("FAIL q5_pop n%0d: got %0d/%h want %0d/%h", n, head_kind5, preview5, m_head(1), m_prev(1));
      end
      step(1'b0, 1'b0, 16'h0, 1'b0);
    end
    pop5 = 1'b0;
    clr5 = 1'b1;
    step(1'b0, 1'b0, 16'h0, 1'b0);
    clr5 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (count5 < 3'd4) begin
        n_cmp++; if (preview5[8:6] !== 3'd0) begin n_bad++; $display("FAIL q5_prev_empty n%0d: got %0d want 0", n, preview5[8:6]); end
      end
      n_cmp++; if (count5 !== 3'(mq[1].size()) || preview5 !== m_prev(1) || head_kind5 !== m_head(1)) begin
        n_bad++; $display("FAIL q5_refill n%0d: got %0d/%h/%0d want %0d/%h/%0d", n, count5, preview5, head_kind5, mq[1].size(), m_prev(1), m_head(1));
      end
      step(1'b0, 1'b0, 16'h0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    int nrec;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    repeat ($urandom_range(9, 9)) step(1'b0, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (count !== 5'd9) begin n_bad++; $display("FAIL mid_count: got %0d want 9", count); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (count !== 5'd0 || head_vld !== 1'b0 || full !== 1'b0) begin
      n_bad++; $display("FAIL async_flags: got %0d/%0b/%0b want 0/0/0", count, head_vld, full);
    end
    n_cmp++; if (head_kind !== 3'd0 || preview !== 9'd0) begin n_bad++; $display("FAIL async_data: got %0d/%h want 0/0", head_kind, preview); end
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    nrec = 0;
    for (int c = 0; c < 21; c++) begin
      if (head_vld && nrec < 20) begin
        n_cmp++; if (head_kind !== ref_seq[nrec]) begin n_bad++; $display("FAIL restart_seq i%0d: got %0d want %0d", nrec, head_kind, ref_seq[nrec]); end
        nrec++;
      end
      step(1'b0, 1'b0, 16'h0, 1'b1);
    end
    n_cmp++; if (nrec != 20) begin n_bad++; $display("FAIL restart_pops: got %0d want 20", nrec); end
  endtask

  task automatic test_random();
    logic c, sl, p;
    logic [15:0] sd;
    for (int n = 0; n < 300; n++) begin
      c  = ($urandom_range(0, 19) == 0);
      sl = ($urandom_range(0, 24) == 0);
      p  = ($urandom_range(0, 2) != 0);
      sd = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      step(c, sl, sd, p);
      n_cmp++; if (head_kind !== m_head(0) || preview !== m_prev(0) || count !== 5'(mq[0].size()) || full !== (mq[0].size() == QS)) begin
        n_bad++; $display("FAIL rand n%0d: got %0d/%h/%0d/%0b want %0d/%h/%0d/%0b", n, head_kind, preview, count, full,
                          m_head(0), m_prev(0), mq[0].size(), mq[0].size() == QS);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop_stream();
    test_clr_pop();
    test_seed_load();
    test_wrap5();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
